// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data responder.
package dmem_responder_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  // Stores only know B/H/W; loads additionally accept the unsigned forms.
  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!wr) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised storage with per-byte-lane write enables and registered word read.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int NUM_LANES   = 4
) (
  input  logic                                clk,
  input  logic                                we_i,
  input  logic [NUM_LANES-1:0]                be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0]      addr_i,
  input  logic [NUM_LANES-1:0][7:0]           wdata_i,
  output logic [NUM_LANES-1:0][7:0]           rdata_o
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[l]) mem[addr_i] <= wdata_i[l];
      rd_q <= mem[addr_i];
    end

    assign rdata_o[l] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: accept, wait LATENCY, commit, respond.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_e            state_q;
  req_t              req_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [BE_W-1:0]   be_d;
  logic [31:0]       wdata_al;
  logic [31:0]       rdata_d;
  logic              err_d;
  logic [1:0]        lane;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              oor;

  // The RAM read is registered, so the word must be addressed on the edge
  // that enters COMMIT; with LATENCY=0 that is the accept edge itself.
  assign ram_addr = (state_q == IDLE) ? req_addr[AW+1:2] : req_q.addr[AW+1:2];
  assign ram_we   = (state_q == COMMIT) && req_q.write && !err_d;

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .NUM_LANES   (BE_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (be_d),
    .addr_i  (ram_addr),
    .wdata_i (wdata_al),
    .rdata_o (ram_rdata)
  );

  assign lane     = req_q.addr[1:0];
  assign byte_sel = ram_rdata[{lane, 3'b000} +: 8];
  assign half_sel = req_q.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
  assign oor      = (req_q.addr >> (AW + 2)) != 32'd0;

  always_comb begin
    err_d    = !f3_legal(req_q.write, req_q.funct3) || oor;
    be_d     = '0;
    wdata_al = '0;
    rdata_d  = '0;
    case (req_q.funct3)
      F3_B, F3_BU: begin
        be_d     = BE_W'(1) << lane;
        wdata_al = {4{req_q.wdata[7:0]}};
        rdata_d  = (req_q.funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      F3_H, F3_HU: begin
        if (req_q.addr[0]) err_d = 1'b1;
        be_d     = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{req_q.wdata[15:0]}};
        rdata_d  = (req_q.funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      F3_W: begin
        if (req_q.addr[1:0] != 2'd0) err_d = 1'b1;
        be_d     = '1;
        wdata_al = req_q.wdata;
        rdata_d  = ram_rdata;
      end
      default: ;
    endcase
    if (err_d || req_q.write) rdata_d = '0;
    if (err_d)                be_d    = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid && req_ready_q) begin
          req_q       <= '{write: req_write, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
          cnt_q       <= LAT4;
          req_ready_q <= 1'b0;
          state_q     <= (LATENCY == 0) ? COMMIT : BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= COMMIT;
        end
        COMMIT: begin
          resp_rdata_q <= rdata_d;
          resp_err_q   <= err_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a byte-array reference model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam int NW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_write, resp_ready, z_resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        a_valid, z_valid;
  logic        a_ready, z_ready, a_rvalid, z_rvalid, a_err, z_err;
  logic [31:0] a_rdata, z_rdata;

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(a_rvalid), .resp_ready(resp_ready), .resp_rdata(a_rdata), .resp_err(a_err));

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_valid), .req_ready(z_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(z_rvalid), .resp_ready(z_resp_ready), .resp_rdata(z_rdata), .resp_err(z_err));

  // sel chooses which instance the op task talks to
  bit          sel = 1'b0;
  logic        s_ready, s_rvalid, s_err;
  logic [31:0] s_rdata;
  assign s_ready  = sel ? z_ready  : a_ready;
  assign s_rvalid = sel ? z_rvalid : a_rvalid;
  assign s_err    = sel ? z_err    : a_err;
  assign s_rdata  = sel ? z_rdata  : a_rdata;

  int vectors = 0, miscompares = 0;
  logic [7:0] mm [NW*4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: size/sign from funct3, alignment by modulo, bytes little-endian.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int size;
    bit sgn;
    logic [31:0] val;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: size = wr ? 0 : 1;
      3'd5: size = wr ? 0 : 2;
      default: size = 0;
    endcase
    sgn = (f3 < 3'd4);
    err = (size == 0) || (a % size != 0) || ((a / 4) >= DW);
    rd  = '0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mm[a+i] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < size; i++) val = val | (32'(mm[a+i]) << (8*i));
        if (sgn && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        rd = val;
      end
    end
  endfunction

  task automatic op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input int hold, input string tag);
    logic e_err;
    logic [31:0] e_rd;
    int n;
    model(wr, f3, a, wd, e_err, e_rd);
    @(negedge clk);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (sel) z_valid = 1'b1; else a_valid = 1'b1;
    chk1({tag, ".rdy"}, s_ready, 1'b1);
    @(posedge clk); #1;
    a_valid = 1'b0; z_valid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, n, sel ? 32'd1 : 32'(LAT + 1));
    chk1({tag, ".err"}, s_err, e_err);
    chk({tag, ".rdata"}, s_rdata, e_rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      a_valid = (h == 0);
      req_addr = 32'h0000_0004;
      @(posedge clk); #1;
      chk1({tag, ".hold_v"}, s_rvalid, 1'b1);
      chk1({tag, ".hold_rdy"}, s_ready, 1'b0);
      chk1({tag, ".hold_e"}, s_err, e_err);
      chk({tag, ".hold_d"}, s_rdata, e_rd);
    end
    @(negedge clk);
    a_valid = 1'b0;
    if (sel) z_resp_ready = 1'b1; else resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; z_resp_ready = 1'b0;
    chk1({tag, ".idle_rdy"}, s_ready, 1'b1);
    chk1({tag, ".idle_v"}, s_rvalid, 1'b0);
    if (hold > 0) begin
      @(posedge clk); #1;
      chk1({tag, ".no_ghost"}, s_rvalid, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; a_valid = 1'b0; z_valid = 1'b0; resp_ready = 1'b0; z_resp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst.rdy", a_ready, 1'b1);
    chk1("rst.rvalid", a_rvalid, 1'b0);
    chk("rst.rdata", a_rdata, 32'd0);
    chk1("rst.err", a_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int w = 0; w < NW; w++) op(1'b1, F3_W, 32'(w*4), $urandom, 0, "init");

    op(1'b1, F3_W,  32'h10, 32'hDEAD_BEEF, 0, "sw10");
    op(1'b0, F3_W,  32'h10, 32'h0, 0, "lw10");
    op(1'b1, F3_B,  32'h13, 32'h0000_0080, 0, "sb13");
    op(1'b0, F3_B,  32'h13, 32'h0, 0, "lb13");
    op(1'b0, F3_BU, 32'h13, 32'h0, 0, "lbu13");
    op(1'b0, F3_W,  32'h10, 32'h0, 0, "lw10b");
    op(1'b1, F3_H,  32'h12, 32'h0000_8001, 0, "sh12");
    op(1'b0, F3_H,  32'h12, 32'h0, 0, "lh12");
    op(1'b0, F3_HU, 32'h12, 32'h0, 0, "lhu12");
    op(1'b0, F3_W,  32'h10, 32'h0, 0, "lw10c");
    op(1'b0, F3_W,  32'h11, 32'h0, 0, "lw_mis");
    op(1'b1, F3_W,  32'h22, 32'hCAFE_F00D, 0, "sw_mis");
    op(1'b0, F3_W,  32'h20, 32'h0, 0, "lw20");
    op(1'b0, 3'd3,  32'h20, 32'h0, 0, "ld_f3");
    op(1'b0, F3_W,  32'(DW*4), 32'h0, 0, "lw_oor");
    op(1'b1, F3_BU, 32'h20, 32'h55, 0, "st_f3");
    op(1'b0, F3_W,  32'h10, 32'h0, 5, "bp");

    // Reset while BUSY drops the store
    @(negedge clk);
    req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h1234_5678; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk1("rstb.rvalid", a_rvalid, 1'b0);
    chk1("rstb.rdy", a_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    op(1'b0, F3_W, 32'h40, 32'h0, 0, "lw40");

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'(DW*4) + $urandom_range(0, 4095);
      else a = $urandom_range(0, NW*4-1);
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0, "rnd");
    end

    sel = 1'b1;
    op(1'b1, F3_W,  32'h0, 32'hA5C3_9681, 0, "l0.sw");
    op(1'b0, F3_W,  32'h0, 32'h0, 0, "l0.lw");
    op(1'b0, F3_B,  32'h3, 32'h0, 0, "l0.lb");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
